// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_pkg
//  Description : Shared defaults, operation encodings and controller state
//                enumeration for mem_access_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 8;
  localparam int unsigned DATA_W_DEFAULT = 16;

  // Request operation encodings (2'b11 is the illegal op)
  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    RESP     = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : Single-request memory access controller driving a
//                synchronous single-port RAM. Supports load, store and an
//                ascending word-serial copy; op 2'b11 completes with an error.
//  Ports       : clk, rst_n (async, active-low)
//                req_valid/req_ready/req_op/req_addr/req_dst/req_len/req_wdata
//                  - request handshake and fields, latched on acceptance
//                rsp_valid/rsp_err/rsp_data - one-cycle completion pulse
//                busy - operation in progress (== !req_ready)
//                mem_addr/mem_wdata/mem_read_enable/mem_write_enable/mem_rdata
//                  - RAM interface (read data returns one cycle after enable)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_dst,
  input  logic [7:0]        req_len,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  // Copy words remaining after the current one; req_len==0 wraps to 255,
  // giving 256 words.
  logic [7:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_re_q, mem_re_d;
  logic              mem_we_q, mem_we_d;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;

    case (state_q)
      // RESP accepts a new request exactly like IDLE so that back-to-back
      // requests run without a bubble.
      IDLE, RESP: begin
        state_d = IDLE;
        if (req_valid) begin
          op_d  = req_op;
          src_d = req_addr;
          dst_d = req_dst;
          cnt_d = req_len - 8'd1;
          case (req_op)
            OP_LOAD, OP_COPY: begin
              mem_re_d   = 1'b1;
              mem_addr_d = req_addr;
              state_d    = RD_ISSUE;
            end
            OP_STORE: begin
              mem_we_d    = 1'b1;
              mem_addr_d  = req_addr;
              mem_wdata_d = req_wdata;
              state_d     = WR_ISSUE;
            end
            default: begin
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_data_d  = '0;
              state_d     = RESP;
            end
          endcase
        end
      end

      RD_ISSUE: state_d = RD_WAIT;

      // Read data is on mem_rdata this cycle.
      RD_WAIT: begin
        if (op_q == OP_LOAD) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = mem_rdata;
          state_d     = RESP;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = dst_q;
          mem_wdata_d = mem_rdata;
          state_d     = WR_ISSUE;
        end
      end

      WR_ISSUE: begin
        if ((op_q == OP_STORE) || (cnt_q == 8'd0)) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          state_d     = RESP;
        end else begin
          cnt_d      = cnt_q - 8'd1;
          src_d      = src_q + ADDR_W'(1);
          dst_d      = dst_q + ADDR_W'(1);
          mem_re_d   = 1'b1;
          mem_addr_d = src_q + ADDR_W'(1);
          state_d    = RD_ISSUE;
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      src_q       <= '0;
      dst_q       <= '0;
      cnt_q       <= 8'd0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
    end
  end

  assign req_ready        = ready_q;
  assign busy             = !ready_q;
  assign rsp_valid        = rsp_valid_q;
  assign rsp_err          = rsp_err_q;
  assign rsp_data         = rsp_data_q;
  assign mem_addr         = mem_addr_q;
  assign mem_wdata        = mem_wdata_q;
  assign mem_read_enable  = mem_re_q;
  assign mem_write_enable = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access_ctrl
//  Description : Directed self-checking bench for mem_access_ctrl with a
//                synchronous single-port RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [7:0]  req_addr;
  logic [7:0]  req_dst;
  logic [7:0]  req_len;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [15:0] rsp_data;
  logic        busy;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [15:0] mem_rdata;

  logic [15:0] mem  [256];
  logic [15:0] snap [256];
  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [15:0] bd_data;

  int n_checks;
  int n_errors;

  mem_access_ctrl #(.ADDR_W(8), .DATA_W(16)) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_op           (req_op),
    .req_addr         (req_addr),
    .req_dst          (req_dst),
    .req_len          (req_len),
    .req_wdata        (req_wdata),
    .rsp_valid        (rsp_valid),
    .rsp_err          (rsp_err),
    .rsp_data         (rsp_data),
    .busy             (busy),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_rdata        (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data one cycle after enable, write commits at edge.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_write_enable) mem[mem_addr] <= mem_wdata;
    if (mem_read_enable) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, let it be accepted at the next edge, then scramble
  // the request fields so any late sampling would be visible.
  task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] dst,
                       input logic [7:0] len, input logic [15:0] wdata);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_dst   = dst;
    req_len   = len;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_op    = 2'b01;
    req_addr  = ~addr;
    req_dst   = ~dst;
    req_len   = 8'd3;
    req_wdata = 16'h5A5A;
  endtask

  // Called in cycle 1; returns the cycle in which rsp_valid was seen
  // (max+1 on timeout) and enable statistics up to and including it.
  task automatic run_rsp(input int max, output int cyc, output int nre, output int nwe,
                         output int nboth);
    cyc = 1; nre = 0; nwe = 0; nboth = 0;
    while (cyc <= max) begin
      if (mem_read_enable) nre++;
      if (mem_write_enable) nwe++;
      if (mem_read_enable && mem_write_enable) nboth++;
      if (rsp_valid) break;
      tick();
      cyc++;
    end
  endtask

  initial begin
    int cyc, nre, nwe, nboth, ndiff, nrsp, nen;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 8'h00;
    req_dst   = 8'h00;
    req_len   = 8'h00;
    req_wdata = 16'h0000;
    bd_we     = 1'b0;
    bd_addr   = 8'h00;
    bd_data   = 16'h0000;

    // Preload mem[i] = 0xA000 + i, mem[0x10] = 0xBEEF while in reset
    tick();
    for (int i = 0; i < 256; i++) begin
      bd_we   = 1'b1;
      bd_addr = 8'(i);
      bd_data = (i == 16) ? 16'hBEEF : 16'hA000 + 16'(i);
      tick();
    end
    bd_we = 1'b0;

    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_enables", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);

    rst_n = 1'b1;
    tick();

    // Load 0x10
    issue(2'b00, 8'h10, 8'h00, 8'h00, 16'h0000);
    chk("ld_c1_re", 32'(mem_read_enable), 32'd1);
    chk("ld_c1_we", 32'(mem_write_enable), 32'd0);
    chk("ld_c1_addr", 32'(mem_addr), 32'h10);
    chk("ld_c1_busy", {30'd0, busy, req_ready}, 32'b10);
    tick();
    chk("ld_c2_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    chk("ld_c2_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("ld_c3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ld_c3_rsp_data", 32'(rsp_data), 32'hBEEF);
    chk("ld_c3_rsp_err", 32'(rsp_err), 32'd0);
    chk("ld_c3_ready", 32'(req_ready), 32'd1);
    tick();
    chk("ld_c4_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("ld_c4_rsp_hold", 32'(rsp_data), 32'hBEEF);

    // Store 0x1234 -> 0xFF, then back-to-back load of 0xFF
    issue(2'b01, 8'hFF, 8'h00, 8'h00, 16'h1234);
    chk("st_c1_we", 32'(mem_write_enable), 32'd1);
    chk("st_c1_re", 32'(mem_read_enable), 32'd0);
    chk("st_c1_addr", 32'(mem_addr), 32'hFF);
    chk("st_c1_wdata", 32'(mem_wdata), 32'h1234);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_addr  = 8'hFF;
    tick();
    chk("st_c2_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("st_c2_rsp_data", 32'(rsp_data), 32'd0);
    chk("st_c2_ready", 32'(req_ready), 32'd1);
    chk("st_mem", 32'(mem[8'hFF]), 32'h1234);
    tick();
    req_valid = 1'b0;
    req_addr  = 8'h00;
    chk("b2b_c1_re", 32'(mem_read_enable), 32'd1);
    chk("b2b_c1_addr", 32'(mem_addr), 32'hFF);
    chk("b2b_c1_rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    tick();
    chk("b2b_c3_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_c3_rsp_data", 32'(rsp_data), 32'h1234);
    tick();

    // Copy src=0xFE dst=0x40 len=4 (wraps the source)
    issue(2'b10, 8'hFE, 8'h40, 8'd4, 16'h0000);
    run_rsp(40, cyc, nre, nwe, nboth);
    chk("cp4_rsp_cycle", 32'(cyc), 32'd13);
    chk("cp4_nre", 32'(nre), 32'd4);
    chk("cp4_nwe", 32'(nwe), 32'd4);
    chk("cp4_both", 32'(nboth), 32'd0);
    chk("cp4_rsp_data", 32'(rsp_data), 32'd0);
    tick();
    chk("cp4_m40", 32'(mem[8'h40]), 32'hA0FE);
    chk("cp4_m41", 32'(mem[8'h41]), 32'h1234);
    chk("cp4_m42", 32'(mem[8'h42]), 32'hA000);
    chk("cp4_m43", 32'(mem[8'h43]), 32'hA001);
    chk("cp4_m44", 32'(mem[8'h44]), 32'hA044);

    // Copy len=0 in place -> 256 words, memory unchanged
    for (int i = 0; i < 256; i++) snap[i] = mem[i];
    issue(2'b10, 8'h00, 8'h00, 8'd0, 16'h0000);
    run_rsp(800, cyc, nre, nwe, nboth);
    chk("cp256_rsp_cycle", 32'(cyc), 32'd769);
    chk("cp256_nre", 32'(nre), 32'd256);
    chk("cp256_nwe", 32'(nwe), 32'd256);
    chk("cp256_both", 32'(nboth), 32'd0);
    tick();
    ndiff = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== snap[i]) ndiff++;
    chk("cp256_unchanged", 32'(ndiff), 32'd0);

    // Illegal op
    issue(2'b11, 8'h22, 8'h33, 8'd1, 16'hFFFF);
    chk("ill_c1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ill_c1_rsp_err", 32'(rsp_err), 32'd1);
    chk("ill_c1_rsp_data", 32'(rsp_data), 32'd0);
    chk("ill_c1_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    tick();
    chk("ill_c2_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("ill_c2_err_hold", 32'(rsp_err), 32'd1);
    chk("ill_c2_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);

    // Reset during cycle 5 of a len=8 copy 0x80 -> 0xC0
    issue(2'b10, 8'h80, 8'hC0, 8'd8, 16'h0000);
    tick(); tick(); tick(); tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    chk("rstmid_addr", 32'(mem_addr), 32'd0);
    chk("rstmid_ready", {30'd0, busy, req_ready}, 32'b01);
    chk("rstmid_err", 32'(rsp_err), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    nrsp = 0;
    nen  = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (rsp_valid) nrsp++;
      if (mem_read_enable || mem_write_enable) nen++;
    end
    chk("rstmid_no_rsp", 32'(nrsp), 32'd0);
    chk("rstmid_no_en", 32'(nen), 32'd0);
    chk("rstmid_mC0", 32'(mem[8'hC0]), 32'hA080);
    chk("rstmid_mC1", 32'(mem[8'hC1]), 32'hA0C1);
    chk("rstmid_mC2", 32'(mem[8'hC2]), 32'hA0C2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ADDR_W, 8, memory word-address width; address arithmetic is modulo 2^ADDR_W.
REQ-002 Parameter DATA_W, 16, memory word width.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  controller can accept a request.
REQ-007 Port req_op  input  2  operation: 00 load, 01 store, 10 copy, 11 illegal.
REQ-008 Port req_addr  input  ADDR_W  load/store address; copy source base.
REQ-009 Port req_dst  input  ADDR_W  copy destination base.
REQ-010 Port req_len  input  8  copy word count; 0 means 256.
REQ-011 Port req_wdata  input  DATA_W  store data.
REQ-012 Port rsp_valid  output  1  one-cycle completion pulse.
REQ-013 Port rsp_err  output  1  completion is for an illegal op; valid only with rsp_valid.
REQ-014 Port rsp_data  output  DATA_W  load result; 0 for store, copy and illegal.
REQ-015 Port busy  output  1  operation in progress; always equals !req_ready.
REQ-016 Ports mem_addr (ADDR_W), mem_wdata (DATA_W), mem_read_enable (1), mem_write_enable (1)  outputs  memory drive; mem_rdata  input  DATA_W  memory read data.

Function
REQ-017 The memory side is a synchronous single-port RAM: a read enabled in cycle N presents data on mem_rdata in cycle N+1; a write enabled in cycle N commits at the end of cycle N.
REQ-018 All outputs are registered; a request is accepted at edge E0 when req_valid and req_ready are both high; "cycle k" means the k-th cycle after E0.
REQ-019 States: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP; req_ready is high only in IDLE and RESP, so back-to-back requests are allowed with no bubble.
REQ-020 Load: cycle 1 mem_read_enable=1, mem_addr=req_addr; cycle 2 idle, mem_rdata captured; cycle 3 rsp_valid=1, rsp_data=captured word.
REQ-021 Store: cycle 1 mem_write_enable=1, mem_addr=req_addr, mem_wdata=req_wdata; cycle 2 rsp_valid=1, rsp_data=0.
REQ-022 Copy word i (0..L-1): cycle 3i+1 read at req_addr+i; cycle 3i+2 capture; cycle 3i+3 write captured word at req_dst+i; cycle 3L+1 rsp_valid=1.
REQ-023 Copy addresses wrap modulo 256; req_len=0 copies 256 words.
REQ-024 Copy is strictly ascending and word-serial, so overlap with dst in (src, src+L) replicates data by design; dst==src rewrites words unchanged.
REQ-025 Illegal op: no memory enable is asserted; cycle 1 rsp_valid=1, rsp_err=1, rsp_data=0.
REQ-026 mem_read_enable and mem_write_enable are never high in the same cycle; both are 0 whenever no access is scheduled.
REQ-027 Request fields are latched at E0; later changes on req_* have no effect on the operation in progress.
REQ-028 rsp_valid is a single-cycle pulse with no backpressure; rsp_data and rsp_err hold their values until the next response.

Reset
REQ-029 While rst_n is low: state=IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_err=0, rsp_data=0, mem_addr=0, mem_wdata=0, and both memory enables=0, applied immediately (asynchronously).
REQ-030 Reset mid-operation abandons the operation with no response; writes already committed remain, and no further enable is issued.

Structure
REQ-031 Package mem_access_pkg holds ADDR_W/DATA_W defaults, the op encodings (OP_LOAD, OP_STORE, OP_COPY) and the state enumeration.
REQ-032 The block is a single module with no sub-module; the copy word counter and the src/dst address registers are internal.

Verification
REQ-033 Preload mem[0x10]=0xBEEF; load 0x10 -> read enable in cycle 1, rsp_valid in cycle 3 with rsp_data=0xBEEF, rsp_err=0.
REQ-034 Store 0x1234 to 0xFF, then load 0xFF back-to-back -> write in cycle 1, ack in cycle 2, second request accepted the same cycle, load returns 0x1234.
REQ-035 Copy src=0xFE, dst=0x40, len=4 -> mem[0x40..0x43]=old mem[0xFE,0xFF,0x00,0x01]; rsp_valid in cycle 13.
REQ-036 Copy len=0, src=0x00, dst=0x00 -> 256 read/write pairs, rsp_valid in cycle 769, memory contents unchanged.
REQ-037 req_op=11 -> rsp_valid and rsp_err in cycle 1, no memory enables asserted.
REQ-038 Assert rst_n low during cycle 5 of a len=8 copy -> enables drop immediately, no rsp_valid; only words 0..0 of the destination are written (word 0 was written in cycle 3).
